serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 9 +
 rtl/serial_adder_if.sv | 20 ++
 rtl/full_adder_1b.sv | 15 +
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encodings and default width shared by the serial adder files
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus
// SERIAL_ADDER_OVF_EN adds the two's-complement overflow flag ovf
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/full_adder_1b.sv
// full_adder_1b: gate-level one-bit full adder cell
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic ab_x, ab_a, c_a;
  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_a, ab_x, cin);
  or  g_o0 (cout, ab_a, c_a);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder cell, WIDTH+1 cycles per op
// SERIAL_ADDER_OVF_EN adds the ovf output (carry into MSB xor carry-out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d, res_sh;
  logic             carry_q, carry_d, cout_q, cout_d, done_q, done_d;
  logic             s, c, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif
  full_adder_1b u_fa (.a(opa_q[0]), .b(opb_q[0]), .cin(carry_q), .sum(s), .cout(c));
  // new sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts
  assign res_sh = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == ST_ADD) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      res_d   = res_sh;
      carry_d = c;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        sum_d   = res_sh;
        cout_d  = c;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = carry_q ^ c;
`endif
      end
    end else if (bus.start) begin
      state_d = ST_ADD;
      opa_d   = bus.a;
      opb_d   = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign bus.busy = state_q == ST_ADD;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;
  logic         held_ovf = 1'b0;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder_if #(.WIDTH(1)) bus1 ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL reset_ctrl: busy/done %b%b want 00", bus.busy, bus.done); end
    n_vec++; if (bus.sum !== '0 || bus.cout !== 1'b0) begin n_err++; $display("FAIL reset_out: sum/cout %h/%b want 00/0", bus.sum, bus.cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy/done %b%b want 00", bus.busy, bus.done); end
  endtask
  task automatic test_arith();
    logic [W-1:0] da [6] = '{8'h3C, 8'hFF, 8'h00, 8'h7F, 8'hFF, 8'hFF};
    logic [W-1:0] db [6] = '{8'h5A, 8'h01, 8'h00, 8'h01, 8'hFF, 8'hFF};
    logic         dc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] x, y;
    logic         c;
    logic [W:0]   e;
    for (int v = 0; v < 26; v++) begin
      x = (v < 6) ? da[v] : W'($urandom);
      y = (v < 6) ? db[v] : W'($urandom);
      c = (v < 6) ? dc[v] : 1'($urandom);
      e = ref_add(x, y, c);
      bus.start = 1'b1; bus.a = x; bus.b = y; bus.cin = c;
      for (int i = 1; i <= W; i++) begin
        @(negedge clk);
        bus.start = (i < W) ? 1'($urandom) : 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        n_vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL add_busy op%0d cyc%0d: busy/done %b%b want 10", v, i, bus.busy, bus.done); end
        n_vec++; if (bus.sum !== held_sum || bus.cout !== held_cout) begin n_err++; $display("FAIL add_hold op%0d cyc%0d: sum/cout %h/%b want %h/%b", v, i, bus.sum, bus.cout, held_sum, held_cout); end
      end
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL done_pulse op%0d: done/busy %b%b want 10", v, bus.done, bus.busy); end
      n_vec++; if (bus.sum !== e[W-1:0] || bus.cout !== e[W]) begin n_err++; $display("FAIL result op%0d %h+%h+%b: sum/cout %h/%b want %h/%b", v, x, y, c, bus.sum, bus.cout, e[W-1:0], e[W]); end
`ifdef SERIAL_ADDER_OVF_EN
      n_vec++; if (bus.ovf !== ref_ovf(x, y, e[W-1:0])) begin n_err++; $display("FAIL ovf op%0d %h+%h+%b: got %b want %b", v, x, y, c, bus.ovf, ref_ovf(x, y, e[W-1:0])); end
      held_ovf = ref_ovf(x, y, e[W-1:0]);
`endif
      held_sum = e[W-1:0];
      held_cout = e[W];
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL after_done op%0d: done/busy %b%b want 00", v, bus.done, bus.busy); end
    end
  endtask
  task automatic test_back_to_back();
    int p [2] = '{0, 0};
    int np = 0;
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    for (int cyc = 1; cyc <= 40 && np < 2; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        p[np] = cyc;
        n_vec++; if (bus.sum !== ((np == 0) ? 8'h30 : 8'h03) || bus.cout !== 1'b0) begin n_err++; $display("FAIL b2b_result%0d: sum/cout %h/%b want %h/0", np, bus.sum, bus.cout, (np == 0) ? 8'h30 : 8'h03); end
        np++;
        if (np == 1) begin bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0; end
        else bus.start = 1'b0;
      end else begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      end
    end
    n_vec++; if (np !== 2) begin n_err++; $display("FAIL b2b_count: %0d done pulses want 2", np); end
    n_vec++; if (p[1] - p[0] !== W + 1) begin n_err++; $display("FAIL b2b_gap: %0d cycles want %0d", p[1] - p[0], W + 1); end
    held_sum = 8'h03; held_cout = 1'b0; held_ovf = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: done/busy %b%b want 00", bus.done, bus.busy); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0;
    repeat (4) begin @(negedge clk); bus.start = 1'b0; end
    n_vec++; if (bus.busy !== 1'b1 || bus.sum !== held_sum) begin n_err++; $display("FAIL mid_busy: busy/sum %b/%h want 1/%h", bus.busy, bus.sum, held_sum); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl: busy/done %b%b want 00", bus.busy, bus.done); end
    n_vec++; if (bus.sum !== '0 || bus.cout !== 1'b0) begin n_err++; $display("FAIL mid_rst_out: sum/cout %h/%b want 00/0", bus.sum, bus.cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf: got %b want 0", bus.ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL mid_no_done: %0d active cycles want 0", seen); end
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    repeat (W) begin @(negedge clk); bus.start = 1'b0; end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b1 || bus.sum !== 8'h02 || bus.cout !== 1'b0) begin n_err++; $display("FAIL mid_fresh: done/sum/cout %b/%h/%b want 1/02/0", bus.done, bus.sum, bus.cout); end
    held_sum = 8'h02;
    @(negedge clk);
  endtask
  task automatic test_width1();
    bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    n_vec++; if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin n_err++; $display("FAIL w1_busy: busy/done %b%b want 10", bus1.busy, bus1.done); end
    @(negedge clk);
    n_vec++; if (bus1.done !== 1'b1 || bus1.busy !== 1'b0) begin n_err++; $display("FAIL w1_done: done/busy %b%b want 10", bus1.done, bus1.busy); end
    n_vec++; if (bus1.sum !== 1'b1 || bus1.cout !== 1'b1) begin n_err++; $display("FAIL w1_result: sum/cout %b/%b want 1/1", bus1.sum, bus1.cout); end
    @(negedge clk);
    n_vec++; if (bus1.done !== 1'b0) begin n_err++; $display("FAIL w1_pulse: done %b want 0", bus1.done); end
  endtask
  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
